npc_pcunit: RTL

NPC_PCUNIT -- requirements
Module: npc_pcunit

---
 rtl/npc_pcunit_pkg.sv | 29 ++
 rtl/npc_target.sv | 65 ++++++
 rtl/npc_pcunit.sv | 107 ++++++++++
 3 files changed

// File: rtl/npc_pcunit_pkg.sv
// Shared definitions for the next-PC unit: the D-stage instruction code table
// and the redirect classification used by the target sub-module.
package npc_pcunit_pkg;

  localparam int INSTR_W = 10;
  typedef logic [INSTR_W-1:0] instr_t;

  // Instruction codes presented on D_inStrType; any other value is sequential.
  localparam instr_t INSTR_NOP  = 10'd0;
  localparam instr_t INSTR_BEQ  = 10'd1;
  localparam instr_t INSTR_BNE  = 10'd2;
  localparam instr_t INSTR_J    = 10'd3;
  localparam instr_t INSTR_JAL  = 10'd4;
  localparam instr_t INSTR_JR   = 10'd5;
  localparam instr_t INSTR_JALR = 10'd6;
  localparam instr_t INSTR_ERET = 10'd7;

  typedef enum logic [1:0] {
    REDIR_NONE   = 2'd0,
    REDIR_BRANCH = 2'd1,
    REDIR_JUMP   = 2'd2,
    REDIR_REG    = 2'd3
  } redir_kind_e;

  function automatic logic [31:0] branch_offset(input logic [15:0] imm16);
    return {{14{imm16[15]}}, imm16, 2'b00};
  endfunction

endpackage

// File: rtl/npc_target.sv
// Decodes the D-stage control-flow instruction and produces the redirect
// target (branch, absolute jump or register jump). Purely combinational.
module npc_target
  import npc_pcunit_pkg::*;
(
  input  instr_t      instr_i,
  input  logic        is_branch_i,
  input  logic [31:0] d_pc_i,
  input  logic [25:0] imm_i,
  input  logic [31:0] rd1_i,
  output logic        redirect_o,
  output logic        is_ctrl_o,
  output logic        is_eret_o,
  output logic [31:0] target_o
);

  redir_kind_e kind_s;

  // Classify the instruction; bne is taken when the comparison is false
  always_comb begin
    kind_s    = REDIR_NONE;
    is_ctrl_o = 1'b0;
    is_eret_o = 1'b0;
    case (instr_i)
      INSTR_BEQ: begin
        is_ctrl_o = 1'b1;
        if (is_branch_i) kind_s = REDIR_BRANCH;
        else             kind_s = REDIR_NONE;
      end
      INSTR_BNE: begin
        is_ctrl_o = 1'b1;
        if (is_branch_i) kind_s = REDIR_NONE;
        else             kind_s = REDIR_BRANCH;
      end
      INSTR_J, INSTR_JAL: begin
        is_ctrl_o = 1'b1;
        kind_s    = REDIR_JUMP;
      end
      INSTR_JR, INSTR_JALR: begin
        is_ctrl_o = 1'b1;
        kind_s    = REDIR_REG;
      end
      INSTR_ERET: begin
        is_eret_o = 1'b1;
      end
      default: begin
        kind_s = REDIR_NONE;
      end
    endcase
  end

  // Target address for the selected redirect kind
  always_comb begin
    target_o = 32'h0000_0000;
    case (kind_s)
      REDIR_BRANCH: target_o = d_pc_i + 32'd4 + branch_offset(imm_i[15:0]);
      REDIR_JUMP:   target_o = {d_pc_i[31:28], imm_i, 2'b00};
      REDIR_REG:    target_o = rd1_i;
      default:      target_o = 32'h0000_0000;
    endcase
  end

  assign redirect_o = (kind_s != REDIR_NONE);

endmodule

// File: rtl/npc_pcunit.sv
// Fetch PC register and next-PC selection with exception/eret handling,
// optional MIPS delay slot, and fetch address-error detection.
module npc_pcunit
  import npc_pcunit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
  parameter bit          DELAY_SLOT = 1'b1,
  parameter logic [31:0] TEXT_LO    = 32'h0000_3000,
  parameter logic [31:0] TEXT_HI    = 32'h0000_6FFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        F_stall,
  input  logic        D_isBranch,
  input  logic [9:0]  D_inStrType,
  input  logic [25:0] D_imm,
  input  logic [31:0] D_RD1,
  input  logic        exc_req,
  input  logic [31:0] exc_epc,
  output logic [31:0] F_PC,
  output logic [31:0] D_PC8,
  output logic        F_flush,
  output logic        F_excAdEL,
  output logic        D_BD
);

  logic [31:0] f_pc_q, f_pc_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] d_pc_q, d_pc_d;
  logic        d_bd_q, d_bd_d;
  logic [31:0] d_pc_s;
  logic        flush_s;
  logic        redirect_s, is_ctrl_s, is_eret_s;
  logic [31:0] target_s;

  // PC of the instruction now in D
  always_comb begin
    if (DELAY_SLOT) d_pc_s = f_pc_q - 32'd4;
    else            d_pc_s = d_pc_q;
  end

  npc_target u_target (
    .instr_i     (D_inStrType),
    .is_branch_i (D_isBranch),
    .d_pc_i      (d_pc_s),
    .imm_i       (D_imm),
    .rd1_i       (D_RD1),
    .redirect_o  (redirect_s),
    .is_ctrl_o   (is_ctrl_s),
    .is_eret_o   (is_eret_s),
    .target_o    (target_s)
  );

  // Next-state selection; exceptions win over stall, D fields only count when unstalled
  always_comb begin
    f_pc_d  = f_pc_q + 32'd4;
    epc_d   = epc_q;
    d_pc_d  = d_pc_q;
    d_bd_d  = d_bd_q;
    flush_s = 1'b0;
    if (exc_req) begin
      f_pc_d  = EXC_VECTOR;
      epc_d   = exc_epc;
      d_pc_d  = f_pc_q;
      d_bd_d  = 1'b0;
      flush_s = 1'b1;
    end else if (F_stall) begin
      f_pc_d = f_pc_q;
    end else begin
      d_pc_d = f_pc_q;
      if (is_eret_s) begin
        f_pc_d  = epc_q;
        flush_s = 1'b1;
      end else if (redirect_s) begin
        f_pc_d  = target_s;
        flush_s = ~DELAY_SLOT;
      end else begin
        f_pc_d = f_pc_q + 32'd4;
      end
      if (flush_s) d_bd_d = 1'b0;
      else         d_bd_d = DELAY_SLOT & is_ctrl_s;
    end
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f_pc_q <= RESET_PC;
      epc_q  <= 32'h0000_0000;
      d_pc_q <= RESET_PC;
      d_bd_q <= 1'b0;
    end else begin
      f_pc_q <= f_pc_d;
      epc_q  <= epc_d;
      d_pc_q <= d_pc_d;
      d_bd_q <= d_bd_d;
    end
  end

  assign F_PC      = f_pc_q;
  assign D_BD      = d_bd_q;
  assign F_flush   = flush_s & ~reset;
  assign D_PC8     = d_pc_s + (DELAY_SLOT ? 32'd8 : 32'd4);
  assign F_excAdEL = (f_pc_q[1:0] != 2'b00) || (f_pc_q < TEXT_LO) || (f_pc_q > TEXT_HI);

endmodule
